// File: rtl/i2c_regfile_pkg.sv
// Shared constants and types for the I2C controller APB register file.
//   - Byte addresses of every register (only paddr[7:0] is decoded).
//   - Bit positions inside CMD and IRQ_EN/IRQ_STAT.
//   - Two-state read FSM type used for the RXDATA wait state.
package i2c_regfile_pkg;

  localparam logic [7:0] ADDR_PRESC    = 8'h00;
  localparam logic [7:0] ADDR_CMD      = 8'h01;
  localparam logic [7:0] ADDR_TXDATA   = 8'h02;
  localparam logic [7:0] ADDR_RXDATA   = 8'h03;
  localparam logic [7:0] ADDR_ADDR_RW  = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h05;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h06;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h07;

  localparam int CMD_EN_BIT = 6;
  localparam logic [7:0] CMD_RESET = 8'h04;

  localparam int IRQ_STOP = 0;  // stop condition completed
  localparam int IRQ_RXAV = 1;  // RX FIFO went non-empty
  localparam int IRQ_ERR  = 2;  // an error response was issued

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rd_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser with rising-edge pulse.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset
//   d_i    : WIDTH-bit signal from a foreign clock domain
//   sync_o : d_i after STAGES flops
//   rise_o : one-cycle pulse per bit when sync_o goes 0->1
module i2c_sync_edge #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]             prev_q, prev_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    prev_d = stage_q[STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = stage_q[STAGES-1];
  assign rise_o = stage_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2c_apb_regfile.sv
// APB slave register file for the I2C controller.
//   APB side   : pclk_i/preset_i, psel/penable/pwrite/paddr/pwdata in,
//                prdata/pready/pslverr out. Zero wait states except a
//                one-cycle wait on RXDATA reads (FIFO pop latency).
//   Core side  : stop_cnt_i and status_i arrive from the core clock and
//                are synchronised here; register contents drive the core.
//   FIFO side  : rx_empty_i/tx_full_i flags, receive_i head data, and
//                single-cycle push/pop strobes.
//   irq_o      : registered OR of enabled IRQ_STAT bits.
module i2c_apb_regfile
  import i2c_regfile_pkg::*;
#(
  parameter int PRESC_W     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int STATUS_W    = 8
) (
  input  logic                pclk_i,
  input  logic                preset_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [31:0]         paddr_i,
  input  logic [31:0]         pwdata_i,
  output logic [31:0]         prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  input  logic                stop_cnt_i,
  input  logic [STATUS_W-1:0] status_i,
  input  logic [7:0]          receive_i,
  input  logic                rx_empty_i,
  input  logic                tx_full_i,
  output logic [PRESC_W-1:0]  prescaler_o,
  output logic [7:0]          cmd_o,
  output logic [7:0]          address_rw_o,
  output logic [7:0]          transmit_o,
  output logic                tx_fifo_write_enable_o,
  output logic                rx_fifo_read_enable_o,
  output logic                irq_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         cmd_q, cmd_d, tx_q, tx_d, addr_q, addr_d;
  logic [2:0]         irq_en_q, irq_en_d, irq_stat_q, irq_stat_d;
  logic               irq_q, irq_d, tx_we_q, tx_we_d, rx_empty_q, rx_empty_d;
  rd_state_t          rd_state_q, rd_state_d;

  logic [7:0]          addr_lo;
  logic                access, unmapped, rx_pop, wr_err, rd_err, wr_ok;
  logic [31:0]         rdata;
  logic                stop_level, stop_rise;
  logic [STATUS_W-1:0] status_sync, status_rise_unused;
  logic                unused_bits;

  i2c_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_stop_sync (
    .clk_i  (pclk_i),
    .rst_i  (preset_i),
    .d_i    (stop_cnt_i),
    .sync_o (stop_level),
    .rise_o (stop_rise)
  );

  i2c_sync_edge #(.WIDTH(STATUS_W), .STAGES(SYNC_STAGES)) u_status_sync (
    .clk_i  (pclk_i),
    .rst_i  (preset_i),
    .d_i    (status_i),
    .sync_o (status_sync),
    .rise_o (status_rise_unused)
  );

  assign unused_bits = ^{paddr_i[31:8], pwdata_i, stop_level, status_rise_unused};

  // Transfer decode and response generation.
  always_comb begin
    addr_lo  = paddr_i[7:0];
    access   = psel_i & penable_i;
    unmapped = (addr_lo > ADDR_IRQ_STAT);
    // The pop is issued in the first access cycle; the FIFO head is then
    // valid during the WAIT cycle that completes the transfer.
    rx_pop   = access & ~pwrite_i & (addr_lo == ADDR_RXDATA) &
               (rd_state_q == IDLE) & ~rx_empty_i;
    pready_o = ~rx_pop;
    wr_err   = unmapped | (addr_lo == ADDR_RXDATA) | (addr_lo == ADDR_STATUS) |
               ((addr_lo == ADDR_TXDATA) & tx_full_i);
    rd_err   = unmapped | ((addr_lo == ADDR_RXDATA) & (rd_state_q == IDLE) & rx_empty_i);
    pslverr_o = access & pready_o & (pwrite_i ? wr_err : rd_err);
    wr_ok    = access & pwrite_i & ~wr_err;
  end

  always_comb begin
    rdata = '0;
    case (addr_lo)
      ADDR_PRESC:    rdata = 32'(presc_q);
      ADDR_CMD:      rdata = {24'b0, cmd_q};
      ADDR_TXDATA:   rdata = {24'b0, tx_q};
      ADDR_RXDATA:   if (rd_state_q == WAIT) rdata = {24'b0, receive_i};
      ADDR_ADDR_RW:  rdata = {24'b0, addr_q};
      ADDR_STATUS:   rdata = 32'(status_sync);
      ADDR_IRQ_EN:   rdata = {29'b0, irq_en_q};
      ADDR_IRQ_STAT: rdata = {29'b0, irq_stat_q};
      default:       rdata = '0;
    endcase
  end

  // Register next-state.
  always_comb begin
    presc_d    = presc_q;
    cmd_d      = cmd_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    irq_en_d   = irq_en_q;
    irq_stat_d = irq_stat_q;
    tx_we_d    = 1'b0;
    rx_empty_d = rx_empty_i;
    rd_state_d = rd_state_q;

    if (wr_ok) begin
      case (addr_lo)
        ADDR_PRESC:    presc_d = pwdata_i[PRESC_W-1:0];
        ADDR_CMD:      cmd_d = pwdata_i[7:0];
        ADDR_TXDATA: begin
          tx_d = pwdata_i[7:0];
          // Suppress a second push if the access phase is held longer.
          tx_we_d = ~tx_we_q;
        end
        ADDR_ADDR_RW:  addr_d = pwdata_i[7:0];
        ADDR_IRQ_EN:   irq_en_d = pwdata_i[2:0];
        ADDR_IRQ_STAT: irq_stat_d = irq_stat_q & ~pwdata_i[2:0];
        default: ;
      endcase
    end

    // Hardware events are applied after the CPU write so they win.
    if (stop_rise) cmd_d[CMD_EN_BIT] = 1'b0;
    irq_stat_d[IRQ_STOP] = irq_stat_d[IRQ_STOP] | stop_rise;
    irq_stat_d[IRQ_RXAV] = irq_stat_d[IRQ_RXAV] | (rx_empty_q & ~rx_empty_i);
    irq_stat_d[IRQ_ERR]  = irq_stat_d[IRQ_ERR] | pslverr_o;

    irq_d = |(irq_stat_q & irq_en_q);

    case (rd_state_q)
      IDLE:    if (rx_pop) rd_state_d = WAIT;
      WAIT:    rd_state_d = IDLE;
      default: rd_state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      presc_q    <= PRESC_W'(4);
      cmd_q      <= CMD_RESET;
      tx_q       <= '0;
      addr_q     <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
      tx_we_q    <= 1'b0;
      rx_empty_q <= 1'b0;
      rd_state_q <= IDLE;
    end else begin
      presc_q    <= presc_d;
      cmd_q      <= cmd_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      irq_q      <= irq_d;
      tx_we_q    <= tx_we_d;
      rx_empty_q <= rx_empty_d;
      rd_state_q <= rd_state_d;
    end
  end

  assign prdata_o               = rdata;
  assign prescaler_o            = presc_q;
  assign cmd_o                  = cmd_q;
  assign address_rw_o           = addr_q;
  assign transmit_o             = tx_q;
  assign tx_fifo_write_enable_o = tx_we_q;
  assign rx_fifo_read_enable_o  = rx_pop;
  assign irq_o                  = irq_q;

endmodule

// File: tb/tb_i2c_apb_regfile.sv
// Bench for i2c_apb_regfile: directed register-map checks followed by
// randomized APB traffic compared against a behavioural register model.
`timescale 1ns/1ps
module tb_i2c_apb_regfile;
  import i2c_regfile_pkg::*;

  localparam int PRESC_W     = 16;
  localparam int SYNC_STAGES = 2;
  localparam int STATUS_W    = 8;
  localparam logic [31:0] PRESC_MASK = 32'((64'd1 << PRESC_W) - 64'd1);

  logic pclk = 1'b0, preset = 1'b1;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic stop_cnt = 1'b0, rx_empty = 1'b1, tx_full = 1'b0;
  logic [STATUS_W-1:0] status_in = '0;
  logic [7:0] receive = '0;

  logic [31:0] prdata_o;
  logic pready_o, pslverr_o, tx_fifo_write_enable_o, rx_fifo_read_enable_o, irq_o;
  logic [PRESC_W-1:0] prescaler_o;
  logic [7:0] cmd_o, address_rw_o, transmit_o;

  always #5 pclk = ~pclk;

  i2c_apb_regfile #(.PRESC_W(PRESC_W), .SYNC_STAGES(SYNC_STAGES), .STATUS_W(STATUS_W)) dut (
    .pclk_i(pclk), .preset_i(preset), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_o),
    .pready_o(pready_o), .pslverr_o(pslverr_o), .stop_cnt_i(stop_cnt),
    .status_i(status_in), .receive_i(receive), .rx_empty_i(rx_empty),
    .tx_full_i(tx_full), .prescaler_o(prescaler_o), .cmd_o(cmd_o),
    .address_rw_o(address_rw_o), .transmit_o(transmit_o),
    .tx_fifo_write_enable_o(tx_fifo_write_enable_o),
    .rx_fifo_read_enable_o(rx_fifo_read_enable_o), .irq_o(irq_o)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Strobe monitor: counts pulses and any strobe held two cycles in a row.
  int tx_pulses = 0, rx_pulses = 0, long_pulses = 0;
  logic tx_prev = 1'b0, rx_prev = 1'b0;
  always @(negedge pclk) begin
    if (tx_fifo_write_enable_o) tx_pulses++;
    if (rx_fifo_read_enable_o) rx_pulses++;
    if ((tx_fifo_write_enable_o && tx_prev) || (rx_fifo_read_enable_o && rx_prev)) long_pulses++;
    tx_prev = tx_fifo_write_enable_o;
    rx_prev = rx_fifo_read_enable_o;
  end

  // Behavioural register model.
  logic [31:0] m_presc;
  logic [7:0]  m_cmd, m_tx, m_addr;
  logic [2:0]  m_en, m_stat;
  int          m_push, m_pop;
  logic        m_stop_pend;

  function automatic void model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                     output logic [31:0] e_rd, output logic e_err, output int e_w);
    logic [7:0] a;
    a = addr[7:0];
    e_rd = '0; e_err = 1'b0; e_w = 0;
    if (wr) begin
      case (a)
        8'd0: m_presc = wd & PRESC_MASK;
        8'd1: m_cmd = wd[7:0];
        8'd2: if (tx_full) e_err = 1'b1; else begin m_tx = wd[7:0]; m_push++; end
        8'd4: m_addr = wd[7:0];
        8'd6: m_en = wd[2:0];
        8'd7: m_stat = m_stat & ~wd[2:0];
        default: e_err = 1'b1;
      endcase
    end else begin
      case (a)
        8'd0: e_rd = m_presc;
        8'd1: e_rd = {24'b0, m_cmd};
        8'd2: e_rd = {24'b0, m_tx};
        8'd3: if (rx_empty) e_err = 1'b1; else begin e_rd = {24'b0, receive}; e_w = 1; m_pop++; end
        8'd4: e_rd = {24'b0, m_addr};
        8'd5: e_rd = 32'(status_in);
        8'd6: e_rd = {29'b0, m_en};
        8'd7: e_rd = {29'b0, m_stat};
        default: e_err = 1'b1;
      endcase
    end
    if (e_err) m_stat[IRQ_ERR] = 1'b1;
    if (m_stop_pend) begin
      m_cmd[CMD_EN_BIT] = 1'b0;
      m_stat[IRQ_STOP] = 1'b1;
      m_stop_pend = 1'b0;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int waits);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    @(negedge pclk);
    while (!pready_o && waits < 8) begin
      waits++;
      @(negedge pclk);
    end
    if (!pready_o) chk("pready_timeout", 32'(pready_o), 32'd1);
    rd = prdata_o;
    err = pslverr_o;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
    logic [31:0] e_rd;
    logic e_err;
    int e_w, w;
    model_xfer(wr, addr, wd, e_rd, e_err, e_w);
    apb_xfer(wr, addr, wd, rd, err, w);
    idle(1);
    $display("xfer %s addr=0x%02h wdata=0x%08h rdata=0x%08h err=%0d", wr ? "WR" : "RD",
             addr[7:0], wd, rd, err);
    chk("pslverr", 32'(err), 32'(e_err));
    if (!wr) chk("prdata", rd, e_rd);
    chk("wait_states", 32'(w), 32'(e_w));
    chk("tx_push_count", 32'(tx_pulses), 32'(m_push));
    chk("rx_pop_count", 32'(rx_pulses), 32'(m_pop));
    chk("prescaler_o", 32'(prescaler_o), m_presc);
    chk("cmd_o", 32'(cmd_o), 32'(m_cmd));
    chk("transmit_o", 32'(transmit_o), 32'(m_tx));
    chk("address_rw_o", 32'(address_rw_o), 32'(m_addr));
    chk("irq_o", 32'(irq_o), 32'(|(m_stat & m_en)));
  endtask

  task automatic set_rx_empty(input logic v);
    if (rx_empty && !v) m_stat[IRQ_RXAV] = 1'b1;
    rx_empty = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, hi, wd, addr;
    logic err, wr;
    int a;

    m_presc = 32'd4; m_cmd = CMD_RESET; m_tx = '0; m_addr = '0;
    m_en = '0; m_stat = '0; m_push = 0; m_pop = 0; m_stop_pend = 1'b0;

    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    chk("reset_irq_o", 32'(irq_o), 32'd0);
    chk("reset_prescaler_o", 32'(prescaler_o), 32'd4);
    chk("reset_cmd_o", 32'(cmd_o), 32'h04);
    chk("reset_pready_idle", 32'(pready_o), 32'd1);

    do_xfer(1'b0, 32'h00, '0, rd, err); chk("rd_presc_reset", rd, 32'h4);
    do_xfer(1'b0, 32'h01, '0, rd, err); chk("rd_cmd_reset", rd, 32'h4);
    do_xfer(1'b0, 32'h06, '0, rd, err); chk("rd_irq_en_reset", rd, 32'h0);

    do_xfer(1'b1, 32'h00, 32'h1234, rd, err);
    chk("presc_1234", 32'(prescaler_o), 32'h1234);
    do_xfer(1'b1, 32'h00, 32'hFFFF_FFFF, rd, err);
    do_xfer(1'b0, 32'h00, '0, rd, err); chk("presc_trunc", rd, 32'h0000_FFFF);

    tx_full = 1'b0;
    do_xfer(1'b1, 32'h02, 32'hA5, rd, err); chk("tx_a5", 32'(transmit_o), 32'hA5);
    tx_full = 1'b1;
    do_xfer(1'b1, 32'h02, 32'h5A, rd, err); chk("tx_full_err", 32'(err), 32'd1);
    do_xfer(1'b0, 32'h07, '0, rd, err); chk("irq_stat_err", rd & 32'h4, 32'h4);
    tx_full = 1'b0;

    receive = 8'h3C; set_rx_empty(1'b0); idle(2);
    do_xfer(1'b0, 32'h03, '0, rd, err); chk("rx_3c", rd, 32'h3C);
    set_rx_empty(1'b1); idle(2);
    do_xfer(1'b0, 32'h03, '0, rd, err); chk("rx_empty_err", 32'(err), 32'd1);

    status_in = 8'h5A; idle(4);
    do_xfer(1'b0, 32'h05, '0, rd, err); chk("status_5a", rd, 32'h5A);
    do_xfer(1'b1, 32'h05, 32'h1, rd, err); chk("wr_status_err", 32'(err), 32'd1);

    // Stop-done: CMD[6] clears after SYNC_STAGES+1 cycles, irq one later.
    do_xfer(1'b1, 32'h07, 32'h7, rd, err);
    do_xfer(1'b1, 32'h01, 32'h44, rd, err);
    do_xfer(1'b1, 32'h06, 32'h1, rd, err);
    stop_cnt = 1'b1;
    idle(SYNC_STAGES);
    chk("stop_cmd_before", 32'(cmd_o), 32'h44);
    idle(1);
    chk("stop_cmd_cleared", 32'(cmd_o), 32'h04);
    chk("stop_irq_before", 32'(irq_o), 32'd0);
    idle(1);
    chk("stop_irq_set", 32'(irq_o), 32'd1);
    m_cmd[CMD_EN_BIT] = 1'b0; m_stat[IRQ_STOP] = 1'b1;
    stop_cnt = 1'b0; idle(4);
    do_xfer(1'b1, 32'h07, 32'h1, rd, err); chk("w1c_irq_clear", 32'(irq_o), 32'd0);

    // CMD write on the stop edge keeps the other bits, enable still cleared.
    stop_cnt = 1'b1; m_stop_pend = 1'b1;
    do_xfer(1'b1, 32'h01, 32'h40, rd, err); chk("cmd_vs_stop", 32'(cmd_o), 32'h00);
    stop_cnt = 1'b0; idle(4);
    // W1C on the stop edge loses to the set.
    stop_cnt = 1'b1; m_stop_pend = 1'b1;
    do_xfer(1'b1, 32'h07, 32'h1, rd, err);
    stop_cnt = 1'b0; idle(4);
    do_xfer(1'b0, 32'h07, '0, rd, err); chk("w1c_vs_stop", rd & 32'h1, 32'h1);

    for (int i = 0; i < 150; i++) begin
      tx_full = 1'($urandom_range(0, 1));
      set_rx_empty(1'($urandom_range(0, 1)));
      receive = 8'($urandom());
      status_in = STATUS_W'($urandom());
      idle(3);
      if ($urandom_range(0, 15) == 0) begin
        stop_cnt = 1'b1; idle(SYNC_STAGES + 2);
        stop_cnt = 1'b0; idle(SYNC_STAGES + 2);
        m_cmd[CMD_EN_BIT] = 1'b0; m_stat[IRQ_STOP] = 1'b1;
      end
      a = $urandom_range(0, 9);
      if (a > 7) a = $urandom_range(8, 255);
      hi = $urandom();
      addr = {hi[31:8], 8'(a)};
      wr = 1'($urandom_range(0, 1));
      wd = $urandom();
      do_xfer(wr, addr, wd, rd, err);
    end

    chk("strobe_single_cycle", 32'(long_pulses), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
